// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM-port arbiter states and the default fetch-fairness bound.
package cpu_types_pkg;

   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } arb_state_t;

   localparam int MAX_DSTREAK_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request, response and RAM-side signals of the shared memory port.
// The master side is the core plus the RAM; the slave side is the arbiter.
interface mem_port_arbiter_if #(parameter int WORD_W = 32);

   logic              iREN;
   logic [WORD_W-1:0] iaddr;
   logic              iwait;
   logic [WORD_W-1:0] iload;
   logic              dREN;
   logic              dWEN;
   logic [WORD_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   logic              dwait;
   logic [WORD_W-1:0] dload;
   logic              halt;
   logic              ramREN;
   logic              ramWEN;
   logic [WORD_W-1:0] ramaddr;
   logic [WORD_W-1:0] ramstore;
   logic [WORD_W-1:0] ramload;
   logic              ram_ready;

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ram_ready,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ram_ready,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

endinterface

// File: rtl/mem_port_arbiter_streak_counter.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_streak_counter #(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic sat
);

   localparam int W = $clog2(MAX + 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != W'(MAX)))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign sat = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single RAM port shared by instruction fetch and data access; data wins unless fetch
// has waited through MAX_DSTREAK data grants. One idle turnaround cycle after each access.
module mem_port_arbiter
   import cpu_types_pkg::*;
#(
   parameter int WORD_W      = 32,
   parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
   input  logic                CLK,
   input  logic                RST,
   mem_port_arbiter_if.slave   bus
);

   arb_state_t state_q;
   arb_state_t state_d;

   logic              dreq;
   logic              ireq;
   logic              sat;
   logic              streak_clr;
   logic              streak_inc;
   logic              ren_c;
   logic              wen_c;
   logic [WORD_W-1:0] addr_c;
   logic [WORD_W-1:0] store_c;

   assign dreq = bus.dREN | bus.dWEN;
   assign ireq = bus.iREN & ~bus.halt;

   // A dropped request leaves its grant just like a completion, but without signalling one.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (dreq && ireq && sat)
               state_d = IGRANT;
            else if (dreq)
               state_d = DGRANT;
            else if (ireq)
               state_d = IGRANT;
         end
         IGRANT:  if (bus.ram_ready || !bus.iREN) state_d = IDLE;
         DGRANT:  if (bus.ram_ready || !dreq)     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   assign streak_inc = (state_q == IDLE) && (state_d == DGRANT) && ireq;
   assign streak_clr = (state_q == IDLE) &&
                       ((state_d == IGRANT) || ((state_d == DGRANT) && !ireq));

   arb_streak_counter #(.MAX(MAX_DSTREAK)) u_streak (
      .clk (CLK),
      .rst (RST),
      .clr (streak_clr),
      .inc (streak_inc),
      .sat (sat)
   );

   always_comb begin
      ren_c   = 1'b0;
      wen_c   = 1'b0;
      addr_c  = '0;
      store_c = '0;
      if (!RST) begin
         case (state_q)
            IGRANT: begin
               ren_c  = bus.iREN;
               addr_c = bus.iaddr;
            end
            DGRANT: begin
               wen_c   = bus.dWEN;
               ren_c   = bus.dREN & ~bus.dWEN;
               addr_c  = bus.daddr;
               store_c = bus.dstore;
            end
            default: ;
         endcase
      end
   end

   assign bus.ramREN   = ren_c;
   assign bus.ramWEN   = wen_c;
   assign bus.ramaddr  = addr_c;
   assign bus.ramstore = store_c;

   assign bus.iwait = bus.iREN & ~(!RST && (state_q == IGRANT) && bus.ram_ready);
   assign bus.dwait = dreq     & ~(!RST && (state_q == DGRANT) && bus.ram_ready);
   assign bus.iload = bus.ramload;
   assign bus.dload = bus.ramload;

endmodule
